// File: rtl/output_port_allocator.sv
// output_port_allocator
// Packet-locked round-robin allocator for one router output port shared by the
// five input ports L,N,E,W,S (bit order 0..4). A requester wins only on a head
// flit and then owns the port until its tail flit. Flits move only while
// downstream credits remain. A stall watchdog frees the port if the owner stops
// sending.
//
// Ports
//   clk          clock
//   rst          asynchronous active-low reset
//   req          per-requester flit-valid
//   flit_id      per-requester flit type, requester i at [3i+2:3i]
//                (001 head, 010 body, 100 tail, 101 single-flit packet)
//   credit_in    one credit returned by downstream this cycle
//   timeout_cfg  stall cycles before forced release, 0 disables the watchdog
//   grant        registered one-hot owner, drives the crossbar select
//   fwd          flit transferred this cycle (combinational)
//   credits      current downstream credit count
//   timeout_err  one-cycle pulse on watchdog release
//   credit_err   one-cycle pulse on a credit returned while already full
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; arbitrate among head flits, grant on next edge
// LOCKED  | owner holds the port until its tail or a watchdog release

module output_port_allocator #(
    parameter int NREQ    = 5,
    parameter int CREDITS = 4,
    parameter int CW      = 3,
    parameter int TW      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] flit_id,
    input  logic              credit_in,
    input  logic [TW-1:0]     timeout_cfg,
    output logic [NREQ-1:0]   grant,
    output logic              fwd,
    output logic [CW-1:0]     credits,
    output logic              timeout_err,
    output logic              credit_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   stall_q, stall_d;
    logic [NREQ-1:0] grant_d;
    logic [CW-1:0]   credits_d;
    logic            timeout_err_d;
    logic            credit_err_d;

    logic [NREQ-1:0] elig;
    logic            any_elig;
    logic [PW-1:0]   win;
    logic [2:0]      owner_fid;
    logic            owner_req;
    logic            owner_last;
    logic            timeout_hit;

    // Round-robin pick: first eligible index after p, wrapping modulo NREQ.
    // The inner loop compares against a constant index so no variable
    // bit-select is needed.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] e,
                                              input logic [PW-1:0]   p);
        logic [PW-1:0] w;
        logic          found;
        w     = p;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && e[i] && (i == ((int'(p) + k) % NREQ))) begin
                    w     = PW'(i);
                    found = 1'b1;
                end
            end
        end
        return w;
    endfunction

    always_comb begin
        elig      = '0;
        owner_fid = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req[i] && ((flit_id[3*i +: 3] == 3'b001) ||
                                 (flit_id[3*i +: 3] == 3'b101));
            if (grant[i]) begin
                owner_fid = owner_fid | flit_id[3*i +: 3];
            end
        end
    end

    assign any_elig    = |elig;
    assign win         = rr_pick(elig, ptr_q);
    assign owner_req   = |(grant & req);
    assign owner_last  = (owner_fid == 3'b100) || (owner_fid == 3'b101);
    assign fwd         = (state_q == ST_LOCKED) && owner_req && (credits != '0);
    assign timeout_hit = (state_q == ST_LOCKED) && !fwd && (timeout_cfg != '0) &&
                         (stall_q == timeout_cfg - TW'(1));

    always_comb begin
        state_d       = state_q;
        grant_d       = grant;
        ptr_d         = ptr_q;
        stall_d       = stall_q;
        timeout_err_d = 1'b0;
        if (state_q == ST_IDLE) begin
            stall_d = '0;
            if (any_elig) begin
                grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win;
                ptr_d   = win;
                state_d = ST_LOCKED;
            end
        end else begin
            if (fwd) begin
                stall_d = '0;
                if (owner_last) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end else if (timeout_hit) begin
                // ptr keeps the stalled owner so it drops to lowest priority
                grant_d       = '0;
                state_d       = ST_IDLE;
                stall_d       = '0;
                timeout_err_d = 1'b1;
            end else begin
                stall_d = stall_q + TW'(1);
            end
        end
    end

    always_comb begin
        credits_d    = credits;
        credit_err_d = 1'b0;
        if (fwd && !credit_in) begin
            credits_d = credits - CW'(1);
        end else if (credit_in && !fwd) begin
            if (credits == CW'(CREDITS)) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            grant       <= '0;
            ptr_q       <= PW'(NREQ - 1);
            stall_q     <= '0;
            credits     <= CW'(CREDITS);
            timeout_err <= 1'b0;
            credit_err  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant       <= grant_d;
            ptr_q       <= ptr_d;
            stall_q     <= stall_d;
            credits     <= credits_d;
            timeout_err <= timeout_err_d;
            credit_err  <= credit_err_d;
        end
    end

endmodule

// File: tb/tb_output_port_allocator.sv
module tb_output_port_allocator;

    logic        clk;
    logic        rst;
    logic [4:0]  req;
    logic [14:0] flit_id;
    logic        credit_in;
    logic [11:0] timeout_cfg;
    logic [4:0]  grant;
    logic        fwd;
    logic [2:0]  credits;
    logic        timeout_err;
    logic        credit_err;

    int checks = 0;
    int passes = 0;

    output_port_allocator #(.NREQ(5), .CREDITS(4), .CW(3), .TW(12)) dut (
        .clk(clk), .rst(rst), .req(req), .flit_id(flit_id),
        .credit_in(credit_in), .timeout_cfg(timeout_cfg),
        .grant(grant), .fwd(fwd), .credits(credits),
        .timeout_err(timeout_err), .credit_err(credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic set_flit(input int i, input logic [2:0] f, input logic r);
        flit_id[3*i +: 3] = f;
        req[i]            = r;
    endtask

    task automatic restore_credits(input int n);
        credit_in = 1'b1;
        repeat (n) adv();
        credit_in = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; req = '0; flit_id = '0; credit_in = 1'b0; timeout_cfg = '0;
        adv(); adv();
        checks++; if (grant !== 5'b00000) $display("FAIL rst_grant: got %b expected 00000", grant); else passes++;
        checks++; if (credits !== 3'd4) $display("FAIL rst_credits: got %0d expected 4", credits); else passes++;
        checks++; if (fwd !== 1'b0) $display("FAIL rst_fwd: got %b expected 0", fwd); else passes++;
        checks++; if (timeout_err !== 1'b0) $display("FAIL rst_terr: got %b expected 0", timeout_err); else passes++;
        checks++; if (credit_err !== 1'b0) $display("FAIL rst_cerr: got %b expected 0", credit_err); else passes++;
        rst = 1'b1;
        adv();
    endtask

    task automatic test_round_robin;
        set_flit(0, 3'b001, 1'b1); set_flit(1, 3'b001, 1'b1); set_flit(2, 3'b001, 1'b1);
        #1;
        checks++; if (fwd !== 1'b0) $display("FAIL t1_idle_fwd: got %b expected 0", fwd); else passes++;
        adv();
        #1;
        checks++; if (grant !== 5'b00001) $display("FAIL t1_grant_L: got %b expected 00001", grant); else passes++;
        checks++; if (fwd !== 1'b1) $display("FAIL t1_fwd_L_head: got %b expected 1", fwd); else passes++;
        adv();
        set_flit(0, 3'b100, 1'b1);
        #1;
        checks++; if (fwd !== 1'b1) $display("FAIL t1_fwd_L_tail: got %b expected 1", fwd); else passes++;
        adv();
        set_flit(0, 3'b000, 1'b0);
        #1;
        checks++; if (grant !== 5'b00000) $display("FAIL t1_release_L: got %b expected 00000", grant); else passes++;
        adv();
        set_flit(1, 3'b101, 1'b1);
        #1;
        checks++; if (grant !== 5'b00010) $display("FAIL t1_grant_N: got %b expected 00010", grant); else passes++;
        checks++; if (fwd !== 1'b1) $display("FAIL t1_fwd_N: got %b expected 1", fwd); else passes++;
        adv();
        set_flit(1, 3'b000, 1'b0);
        #1;
        checks++; if (grant !== 5'b00000) $display("FAIL t1_release_N: got %b expected 00000", grant); else passes++;
        adv();
        set_flit(2, 3'b101, 1'b1);
        #1;
        checks++; if (grant !== 5'b00100) $display("FAIL t1_grant_E: got %b expected 00100", grant); else passes++;
        adv();
        set_flit(2, 3'b000, 1'b0);
        #1;
        checks++; if (credits !== 3'd0) $display("FAIL t1_credits_end: got %0d expected 0", credits); else passes++;
        restore_credits(4);
        #1;
        checks++; if (credits !== 3'd4) $display("FAIL t1_credits_restored: got %0d expected 4", credits); else passes++;
    endtask

    task automatic test_credit_drain;
        logic [2:0] pkt [4];
        pkt[0] = 3'b001; pkt[1] = 3'b010; pkt[2] = 3'b010; pkt[3] = 3'b100;
        set_flit(1, 3'b001, 1'b1);
        #1;
        checks++; if (grant !== 5'b00000) $display("FAIL t2_idle_grant: got %b expected 00000", grant); else passes++;
        adv();
        for (int k = 0; k < 4; k++) begin
            set_flit(1, pkt[k], 1'b1);
            #1;
            checks++; if (fwd !== 1'b1) $display("FAIL t2_fwd_%0d: got %b expected 1", k, fwd); else passes++;
            checks++; if (credits !== 3'(4 - k)) $display("FAIL t2_credits_%0d: got %0d expected %0d", k, credits, 4 - k); else passes++;
            adv();
        end
        set_flit(1, 3'b000, 1'b0);
        set_flit(3, 3'b001, 1'b1);
        #1;
        checks++; if (credits !== 3'd0) $display("FAIL t2_credits_zero: got %0d expected 0", credits); else passes++;
        checks++; if (grant !== 5'b00000) $display("FAIL t2_release: got %b expected 00000", grant); else passes++;
        adv();
        credit_in = 1'b1;
        set_flit(3, 3'b101, 1'b1);
        #1;
        checks++; if (grant !== 5'b01000) $display("FAIL t2_grant_W_no_credit: got %b expected 01000", grant); else passes++;
        checks++; if (fwd !== 1'b0) $display("FAIL t2_fwd_no_credit: got %b expected 0", fwd); else passes++;
        adv();
        credit_in = 1'b0;
        #1;
        checks++; if (fwd !== 1'b1) $display("FAIL t2_fwd_W: got %b expected 1", fwd); else passes++;
        adv();
        set_flit(3, 3'b000, 1'b0);
        #1;
        checks++; if (grant !== 5'b00000) $display("FAIL t2_release_W: got %b expected 00000", grant); else passes++;
    endtask

    task automatic test_credit_stall;
        set_flit(2, 3'b001, 1'b1);
        #1;
        adv();
        credit_in = 1'b1;
        #1;
        checks++; if (grant !== 5'b00100) $display("FAIL t3_grant_E: got %b expected 00100", grant); else passes++;
        checks++; if (fwd !== 1'b0) $display("FAIL t3_fwd_zero_credit: got %b expected 0", fwd); else passes++;
        adv();
        credit_in = 1'b0;
        #1;
        checks++; if (credits !== 3'd1) $display("FAIL t3_credit_back: got %0d expected 1", credits); else passes++;
        checks++; if (fwd !== 1'b1) $display("FAIL t3_fwd_after_credit: got %b expected 1", fwd); else passes++;
        adv();
        set_flit(2, 3'b010, 1'b1);
        credit_in = 1'b1;
        #1;
        checks++; if (fwd !== 1'b0) $display("FAIL t3_fwd_zero_again: got %b expected 0", fwd); else passes++;
        adv();
        #1;
        checks++; if (fwd !== 1'b1) $display("FAIL t3_fwd_with_credit_in: got %b expected 1", fwd); else passes++;
        adv();
        credit_in = 1'b0;
        set_flit(2, 3'b100, 1'b1);
        #1;
        checks++; if (credits !== 3'd1) $display("FAIL t3_credits_unchanged: got %0d expected 1", credits); else passes++;
        checks++; if (fwd !== 1'b1) $display("FAIL t3_fwd_tail: got %b expected 1", fwd); else passes++;
        adv();
        set_flit(2, 3'b000, 1'b0);
        #1;
        checks++; if (grant !== 5'b00000) $display("FAIL t3_release: got %b expected 00000", grant); else passes++;
        checks++; if (credits !== 3'd0) $display("FAIL t3_credits_end: got %0d expected 0", credits); else passes++;
        restore_credits(4);
    endtask

    task automatic test_watchdog;
        timeout_cfg = 12'd5;
        set_flit(4, 3'b001, 1'b1);
        #1;
        adv();
        #1;
        checks++; if (grant !== 5'b10000) $display("FAIL t4_grant_S: got %b expected 10000", grant); else passes++;
        checks++; if (fwd !== 1'b1) $display("FAIL t4_fwd_S_head: got %b expected 1", fwd); else passes++;
        adv();
        set_flit(4, 3'b010, 1'b0);
        #1;
        checks++; if (timeout_err !== 1'b0) $display("FAIL t4_no_err_0: got %b expected 0", timeout_err); else passes++;
        for (int k = 1; k <= 4; k++) begin
            adv();
            #1;
            checks++; if (timeout_err !== 1'b0) $display("FAIL t4_no_err_%0d: got %b expected 0", k, timeout_err); else passes++;
            checks++; if (grant !== 5'b10000) $display("FAIL t4_hold_%0d: got %b expected 10000", k, grant); else passes++;
        end
        adv();
        #1;
        checks++; if (timeout_err !== 1'b1) $display("FAIL t4_err_pulse: got %b expected 1", timeout_err); else passes++;
        checks++; if (grant !== 5'b00000) $display("FAIL t4_forced_release: got %b expected 00000", grant); else passes++;
        set_flit(0, 3'b001, 1'b1);
        set_flit(4, 3'b001, 1'b1);
        #1;
        adv();
        set_flit(0, 3'b101, 1'b1);
        #1;
        checks++; if (timeout_err !== 1'b0) $display("FAIL t4_err_one_cycle: got %b expected 0", timeout_err); else passes++;
        checks++; if (grant !== 5'b00001) $display("FAIL t4_L_before_S: got %b expected 00001", grant); else passes++;
        adv();
        set_flit(0, 3'b000, 1'b0);
        #1;
        adv();
        set_flit(4, 3'b101, 1'b1);
        #1;
        checks++; if (grant !== 5'b10000) $display("FAIL t4_S_after_L: got %b expected 10000", grant); else passes++;
        adv();
        set_flit(4, 3'b000, 1'b0);
        timeout_cfg = '0;
        #1;
        checks++; if (credits !== 3'd1) $display("FAIL t4_credits: got %0d expected 1", credits); else passes++;
        restore_credits(3);
    endtask

    task automatic test_credit_err_single;
        #1;
        checks++; if (credits !== 3'd4) $display("FAIL t5_credits_full: got %0d expected 4", credits); else passes++;
        credit_in = 1'b1;
        adv();
        credit_in = 1'b0;
        #1;
        checks++; if (credit_err !== 1'b1) $display("FAIL t5_cerr_pulse: got %b expected 1", credit_err); else passes++;
        checks++; if (credits !== 3'd4) $display("FAIL t5_credits_hold: got %0d expected 4", credits); else passes++;
        adv();
        set_flit(3, 3'b101, 1'b1);
        #1;
        checks++; if (credit_err !== 1'b0) $display("FAIL t5_cerr_one_cycle: got %b expected 0", credit_err); else passes++;
        adv();
        #1;
        checks++; if (grant !== 5'b01000) $display("FAIL t5_grant_W: got %b expected 01000", grant); else passes++;
        checks++; if (fwd !== 1'b1) $display("FAIL t5_fwd_W: got %b expected 1", fwd); else passes++;
        adv();
        set_flit(3, 3'b000, 1'b0);
        #1;
        checks++; if (grant !== 5'b00000) $display("FAIL t5_release_W: got %b expected 00000", grant); else passes++;
        checks++; if (credits !== 3'd3) $display("FAIL t5_credits_after: got %0d expected 3", credits); else passes++;
        restore_credits(1);
    endtask

    task automatic test_async_reset;
        set_flit(0, 3'b001, 1'b1);
        adv();
        #1;
        checks++; if (grant !== 5'b00001) $display("FAIL t6_grant_L: got %b expected 00001", grant); else passes++;
        adv();
        set_flit(0, 3'b010, 1'b1);
        #1;
        checks++; if (credits !== 3'd3) $display("FAIL t6_credits_mid: got %0d expected 3", credits); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (grant !== 5'b00000) $display("FAIL t6_async_grant: got %b expected 00000", grant); else passes++;
        checks++; if (credits !== 3'd4) $display("FAIL t6_async_credits: got %0d expected 4", credits); else passes++;
        checks++; if (fwd !== 1'b0) $display("FAIL t6_async_fwd: got %b expected 0", fwd); else passes++;
        req = '0; flit_id = '0;
        adv();
        rst = 1'b1;
        set_flit(0, 3'b001, 1'b1);
        set_flit(1, 3'b001, 1'b1);
        #1;
        adv();
        #1;
        checks++; if (grant !== 5'b00001) $display("FAIL t6_restart_L: got %b expected 00001", grant); else passes++;
        req = '0; flit_id = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credit_drain();
        test_credit_stall();
        test_watchdog();
        test_credit_err_single();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
